// File: rtl/register_file_2r1w.sv
// register_file_2r1w
//   2**ADDR_W x DATA_W register file with two registered read ports and one
//   write port. Register 0 is hardwired to zero and writes to it are dropped.
//
//   Ports
//     clk       : single clock, rising edge
//     rst       : synchronous active-high reset. Clears every register, both
//                 read outputs and rd_valid. Takes priority over we and re.
//     we/wa/wd  : write enable, address and data
//     re        : read request, shared by both read ports
//     ra1/ra2   : read addresses
//     rd1/rd2   : read data, registered. Holds its value while re=0.
//     rd_valid  : one cycle after a request. Stays high for back-to-back reads.
//
//   Configuration macro: REGFILE_BYPASS_EN
//     defined   : write-first. A same-cycle write and read of the same nonzero
//                 address returns wd.
//     undefined : read-first. Such a read returns the old stored value.
//                 The new value appears on the next read.
//   Bypass never applies to address 0. Each port decides it on its own.

// Output register for one read port.
module register_file_2r1w_rdport #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  always_ff @(posedge clk) begin
    if (rst)     dout <= '0;
    else if (re) dout <= din;
  end
endmodule

module register_file_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              rd_valid
);
  localparam int NREG   = 1 << ADDR_W;
  localparam int NPORT  = 2;
  localparam int STAGES = 1;

  logic [NREG-1:0][DATA_W-1:0]   mem;
  logic [NPORT-1:0][ADDR_W-1:0]  ra_v;
  logic [NPORT-1:0][DATA_W-1:0]  rsel;
  logic [NPORT-1:0][DATA_W-1:0]  rq;
  logic [STAGES:1]               vld_pipe;
  logic                          wen;

  assign ra_v = {ra2, ra1};
  // Writes to register 0 are filtered out here.
  // This also keeps the bypass path from ever matching address 0.
  assign wen  = we && (wa != '0);

  // Entry 0 is only ever cleared, never written.
  always_ff @(posedge clk) begin
    if (rst)      mem     <= '0;
    else if (wen) mem[wa] <= wd;
  end

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    logic [DATA_W-1:0] stored;
    // Address 0 is forced to zero explicitly. It does not depend on mem[0]
    // having been reset.
    assign stored = (ra_v[p] == '0) ? '0 : mem[ra_v[p]];
`ifdef REGFILE_BYPASS_EN
    assign rsel[p] = (wen && (wa == ra_v[p])) ? wd : stored;
`else
    assign rsel[p] = stored;
`endif
    register_file_2r1w_rdport #(.DATA_W(DATA_W)) u_rd (
      .clk  (clk),
      .rst  (rst),
      .re   (re),
      .din  (rsel[p]),
      .dout (rq[p])
    );
  end

  // rd_valid tracks re with read latency, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) vld_pipe[1] <= 1'b0;
    else     vld_pipe[1] <= re;
  end

  assign rd1      = rq[0];
  assign rd2      = rq[1];
  assign rd_valid = vld_pipe[STAGES];
endmodule
